// File: rtl/pcd8544_spi_receiver.sv
// Display-side PCD8544 serial receiver: oversamples the LCD SPI link, decodes
// commands, tracks controller registers and X/Y counters, and mirrors the display RAM.
module pcd8544_spi_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 84,
    parameter int BANKS       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       DC,
    input  logic       CS,
    input  logic       LCD_reset,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_is_data,
    output logic       cmd_err,
    output logic       ram_we,
    output logic [8:0] ram_addr,
    output logic [6:0] x_addr,
    output logic [2:0] y_addr,
    output logic       power_down,
    output logic       vaddr_mode,
    output logic       ext_instr,
    output logic [1:0] disp_mode,
    output logic [6:0] vop,
    output logic [2:0] bias,
    output logic [1:0] temp_coef,
    input  logic [8:0] rd_addr,
    output logic [7:0] rd_data
);
    localparam int         DEPTH  = COLS * BANKS;
    localparam int         NSYNC  = 5;
    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [2:0] Y_LAST = 3'(BANKS - 1);
    localparam logic [7:0] X_LIM  = 8'(COLS);
    localparam logic [3:0] Y_LIM  = 4'(BANKS);
    // Chains idle with CS deasserted and the controller held in reset.
    localparam logic [NSYNC-1:0][SYNC_STAGES-1:0] SYNC_RST =
        {{SYNC_STAGES{1'b0}}, {SYNC_STAGES{1'b1}}, {(3*SYNC_STAGES){1'b0}}};

    logic [NSYNC-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NSYNC-1:0] sync_in, sync_out;
    logic sck_s, mosi_s, dc_s, cs_s, lcd_rst_n_s, sck_rise;

    logic       sck_prev_q, sck_prev_d;
    logic [6:0] sh_q, sh_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] byte_q, byte_d;
    logic       dc_q, dc_d;
    logic       pend_q, pend_d;
    logic [6:0] x_q, x_d;
    logic [2:0] y_q, y_d;
    logic       pd_q, pd_d, v_q, v_d, h_q, h_d;
    logic [1:0] dm_q, dm_d;
    logic [6:0] vop_q, vop_d;
    logic [2:0] bias_q, bias_d;
    logic [1:0] tc_q, tc_d;
    logic [7:0] rd_data_q;
    logic [7:0] mem [DEPTH];

    assign sync_in = {LCD_reset, CS, DC, MOSI, SCK};

    always_comb begin
        for (int i = 0; i < NSYNC; i++) begin
            sync_d[i][0] = sync_in[i];
            for (int s = 1; s < SYNC_STAGES; s++) sync_d[i][s] = sync_q[i][s-1];
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    assign {lcd_rst_n_s, cs_s, dc_s, mosi_s, sck_s} = sync_out;
    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_prev_d = sck_s;

    always_comb begin
        sh_d    = sh_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        dc_d    = dc_q;
        pend_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        pd_d    = pd_q;
        v_d     = v_q;
        h_d     = h_q;
        dm_d    = dm_q;
        vop_d   = vop_q;
        bias_d  = bias_q;
        tc_d    = tc_q;
        cmd_err = 1'b0;

        if (cs_s) begin
            sh_d  = '0;
            bit_d = '0;
        end else if (sck_rise) begin
            if (bit_q == 3'd7) begin
                byte_d = {sh_q, mosi_s};
                dc_d   = dc_s;
                pend_d = 1'b1;
                sh_d   = '0;
                bit_d  = '0;
            end else begin
                sh_d  = {sh_q[5:0], mosi_s};
                bit_d = bit_q + 3'd1;
            end
        end

        if (pend_q && dc_q) begin
            if (!v_q) begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? 3'd0 : y_q + 3'd1;
                end else begin
                    x_d = x_q + 7'd1;
                end
            end else begin
                if (y_q == Y_LAST) begin
                    y_d = '0;
                    x_d = (x_q == X_LAST) ? 7'd0 : x_q + 7'd1;
                end else begin
                    y_d = y_q + 3'd1;
                end
            end
        end else if (pend_q) begin
            if (byte_q[7:3] == 5'b00100) begin
                {pd_d, v_d, h_d} = byte_q[2:0];
            end else if (byte_q != 8'h00) begin
                if (!h_q) begin
                    if (byte_q[7:3] == 5'b00001) begin
                        dm_d = {byte_q[2], byte_q[0]};
                    end else if (byte_q[7:3] == 5'b01000) begin
                        if ({1'b0, byte_q[2:0]} >= Y_LIM) cmd_err = 1'b1;
                        else y_d = byte_q[2:0];
                    end else if (byte_q[7]) begin
                        if ({1'b0, byte_q[6:0]} >= X_LIM) cmd_err = 1'b1;
                        else x_d = byte_q[6:0];
                    end else begin
                        cmd_err = 1'b1;
                    end
                end else begin
                    if (byte_q[7:2] == 6'b000001) tc_d = byte_q[1:0];
                    else if (byte_q[7:3] == 5'b00010) bias_d = byte_q[2:0];
                    else if (byte_q[7]) vop_d = byte_q[6:0];
                    else cmd_err = 1'b1;
                end
            end
        end

        // Controller reset also drops any partial or pending byte.
        if (!lcd_rst_n_s) begin
            sh_d   = '0;
            bit_d  = '0;
            byte_d = '0;
            dc_d   = 1'b0;
            pend_d = 1'b0;
            x_d    = '0;
            y_d    = '0;
            pd_d   = 1'b1;
            v_d    = 1'b0;
            h_d    = 1'b0;
            dm_d   = '0;
            vop_d  = '0;
            bias_d = '0;
            tc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= SYNC_RST;
            sck_prev_q <= 1'b0;
            sh_q       <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            dc_q       <= 1'b0;
            pend_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            pd_q       <= 1'b1;
            v_q        <= 1'b0;
            h_q        <= 1'b0;
            dm_q       <= '0;
            vop_q      <= '0;
            bias_q     <= '0;
            tc_q       <= '0;
            rd_data_q  <= '0;
        end else begin
            sync_q     <= sync_d;
            sck_prev_q <= sck_prev_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            dc_q       <= dc_d;
            pend_q     <= pend_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pd_q       <= pd_d;
            v_q        <= v_d;
            h_q        <= h_d;
            dm_q       <= dm_d;
            vop_q      <= vop_d;
            bias_q     <= bias_d;
            tc_q       <= tc_d;
            rd_data_q  <= mem[rd_addr];
        end
    end

    // Display RAM is never cleared; reads return pre-write data on collision.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= byte_q;
    end

    assign byte_valid   = pend_q;
    assign byte_out     = byte_q;
    assign byte_is_data = dc_q;
    assign ram_we       = pend_q & dc_q;
    assign ram_addr     = 9'(y_q) * 9'(COLS) + 9'(x_q);
    assign x_addr       = x_q;
    assign y_addr       = y_q;
    assign power_down   = pd_q;
    assign vaddr_mode   = v_q;
    assign ext_instr    = h_q;
    assign disp_mode    = dm_q;
    assign vop          = vop_q;
    assign bias         = bias_q;
    assign temp_coef    = tc_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_pcd8544_spi_receiver.sv
// Bench for pcd8544_spi_receiver: directed plus random SPI traffic against a
// linear-address reference model of the controller and its display RAM.
module tb_pcd8544_spi_receiver;
    logic clk = 1'b0;
    logic rst, SCK, MOSI, DC, CS, LCD_reset;
    logic [8:0] rd_addr;
    logic byte_valid, byte_is_data, cmd_err, ram_we;
    logic power_down, vaddr_mode, ext_instr;
    logic [7:0] byte_out, rd_data;
    logic [8:0] ram_addr;
    logic [6:0] x_addr, vop;
    logic [2:0] y_addr, bias;
    logic [1:0] disp_mode, temp_coef;

    pcd8544_spi_receiver dut (
        .clk(clk), .rst(rst), .SCK(SCK), .MOSI(MOSI), .DC(DC), .CS(CS),
        .LCD_reset(LCD_reset), .byte_valid(byte_valid), .byte_out(byte_out),
        .byte_is_data(byte_is_data), .cmd_err(cmd_err), .ram_we(ram_we),
        .ram_addr(ram_addr), .x_addr(x_addr), .y_addr(y_addr),
        .power_down(power_down), .vaddr_mode(vaddr_mode), .ext_instr(ext_instr),
        .disp_mode(disp_mode), .vop(vop), .bias(bias), .temp_coef(temp_coef),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: RAM as a flat 504-entry array, address as a linear index.
    logic [7:0] mmem [504];
    bit         mwr  [504];
    int mx, my, mpd, mv, mh, mdm, mvop, mbias, mtc;
    int exp_valid = 0, exp_we = 0, exp_err = 0;

    int n_valid = 0, n_we = 0, n_err = 0;
    logic [7:0] last_byte = 8'h00;
    logic       last_dc = 1'b0;

    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            n_valid++;
            last_byte = byte_out;
            last_dc   = byte_is_data;
        end
        if (ram_we === 1'b1) n_we++;
        if (cmd_err === 1'b1) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mpd = 1; mv = 0; mh = 0;
        mdm = 0; mvop = 0; mbias = 0; mtc = 0;
    endtask

    task automatic model_apply(input logic [7:0] b, input logic dc);
        int a, bi;
        bi = int'(b);
        exp_valid++;
        if (dc) begin
            exp_we++;
            a = my * 84 + mx;
            mmem[a] = b;
            mwr[a]  = 1'b1;
            if (mv == 0) begin
                a = (a + 1) % 504; mx = a % 84; my = a / 84;
            end else begin
                a = (mx * 6 + my + 1) % 504; mx = a / 6; my = a % 6;
            end
        end else if (bi >= 'h20 && bi <= 'h27) begin
            mpd = (bi >> 2) & 1; mv = (bi >> 1) & 1; mh = bi & 1;
        end else if (bi == 0) begin
            mpd = mpd;
        end else if (mh == 0) begin
            if (bi >= 'h08 && bi <= 'h0F) mdm = ((bi >> 2) & 1) * 2 + (bi & 1);
            else if (bi >= 'h40 && bi <= 'h47) begin
                if (bi - 'h40 >= 6) exp_err++; else my = bi - 'h40;
            end else if (bi >= 'h80) begin
                if (bi - 'h80 >= 84) exp_err++; else mx = bi - 'h80;
            end else exp_err++;
        end else begin
            if (bi >= 'h04 && bi <= 'h07) mtc = bi % 4;
            else if (bi >= 'h10 && bi <= 'h17) mbias = bi % 8;
            else if (bi >= 'h80) mvop = bi - 'h80;
            else exp_err++;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".x"}, 32'(x_addr), mx);
        check({tag, ".y"}, 32'(y_addr), my);
        check({tag, ".pd"}, 32'(power_down), mpd);
        check({tag, ".v"}, 32'(vaddr_mode), mv);
        check({tag, ".h"}, 32'(ext_instr), mh);
        check({tag, ".dm"}, 32'(disp_mode), mdm);
        check({tag, ".vop"}, 32'(vop), mvop);
        check({tag, ".bias"}, 32'(bias), mbias);
        check({tag, ".tc"}, 32'(temp_coef), mtc);
        check({tag, ".nvalid"}, n_valid, exp_valid);
        check({tag, ".nwe"}, n_we, exp_we);
        check({tag, ".nerr"}, n_err, exp_err);
    endtask

    // Shifts the n most significant bits of b, 8 clocks per SCK period.
    task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            MOSI = b[i];
            DC   = dc;
            repeat (3) @(negedge clk);
            SCK = 1'b1;
            repeat (4) @(negedge clk);
            SCK = 1'b0;
        end
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8);
        repeat (6) @(negedge clk);
        model_apply(b, dc);
        check({tag, ".byte_out"}, 32'(last_byte), 32'(b));
        check({tag, ".is_data"}, 32'(last_dc), 32'(dc));
        check_state(tag);
    endtask

    task automatic read_check(input string tag, input int a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = 9'(a);
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        logic [7:0] rb;
        logic       rdc;
        int         cat;
        rst = 1'b1; SCK = 1'b0; MOSI = 1'b0; DC = 1'b0; CS = 1'b1;
        LCD_reset = 1'b1; rd_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("rst");
        check("rst.byte_valid", 32'(byte_valid), 0);
        check("rst.rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        LCD_reset = 1'b0;
        repeat (4) @(negedge clk);
        check_state("lcdrst");
        check("lcdrst.ram_we", 32'(ram_we), 0);
        LCD_reset = 1'b1;
        repeat (4) @(negedge clk);
        CS = 1'b0;

        // Controller init sequence
        send_byte("init0", 8'h21, 1'b0);
        send_byte("init1", 8'hBF, 1'b0);
        send_byte("init2", 8'h04, 1'b0);
        send_byte("init3", 8'h14, 1'b0);
        send_byte("init4", 8'h20, 1'b0);
        send_byte("init5", 8'h0C, 1'b0);
        check("init.vop", 32'(vop), 32'h3F);
        check("init.bias", 32'(bias), 4);
        check("init.dm", 32'(disp_mode), 2);
        check("init.nerr", n_err, 0);

        // Horizontal wrap from the last cell
        send_byte("hw0", 8'h45, 1'b0);
        send_byte("hw1", 8'hD3, 1'b0);
        send_byte("hw2", 8'hA5, 1'b1);
        send_byte("hw3", 8'h3C, 1'b1);
        read_check("hw.ram503", 503, 8'hA5);
        read_check("hw.ram0", 0, 8'h3C);

        // Vertical addressing
        send_byte("vm0", 8'h22, 1'b0);
        send_byte("vm1", 8'h80, 1'b0);
        send_byte("vm2", 8'h40, 1'b0);
        for (int i = 1; i <= 7; i++) send_byte("vmd", 8'(i), 1'b1);
        for (int i = 0; i < 6; i++) read_check("vm.col0", i * 84, 8'(i + 1));
        read_check("vm.ram1", 1, 8'h07);
        check("vm.x", 32'(x_addr), 1);
        check("vm.y", 32'(y_addr), 1);

        // Out-of-range address commands
        send_byte("err0", 8'h46, 1'b0);
        send_byte("err1", 8'hD4, 1'b0);

        // CS abort mid-byte
        send_bits(8'hFF, 1'b0, 5);
        repeat (2) @(negedge clk);
        CS = 1'b1;
        repeat (6) @(negedge clk);
        CS = 1'b0;
        repeat (4) @(negedge clk);
        send_byte("csab", 8'h81, 1'b0);
        check("csab.x", 32'(x_addr), 1);

        // Controller reset mid-byte
        send_bits(8'h5A, 1'b1, 3);
        repeat (2) @(negedge clk);
        LCD_reset = 1'b0;
        repeat (4) @(negedge clk);
        LCD_reset = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check_state("lrst");
        send_byte("lrst.data", 8'hC3, 1'b1);
        read_check("lrst.ram0", 0, 8'hC3);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            cat = int'($urandom_range(0, 5));
            rdc = 1'b0;
            case (cat)
                0: rb = 8'h20 | 8'($urandom_range(0, 7));
                1: rb = 8'h80 | 8'($urandom_range(0, 127));
                2: rb = 8'h40 | 8'($urandom_range(0, 7));
                3: rb = 8'($urandom_range(0, 255));
                default: begin rb = 8'($urandom_range(0, 255)); rdc = 1'b1; end
            endcase
            send_byte("rnd", rb, rdc);
        end
        for (int a = 0; a < 504; a++)
            if (mwr[a]) read_check("rnd.ram", a, mmem[a]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
